// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, asynchronous-read instruction memory
// port and a 2-entry {instr, pc} queue feeding decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          IM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic [10:0] im_addr,
  input  logic [31:0] im_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        fetch_fault
);

  // Handshake: the head entry transfers to decode on any rising edge where
  // if_valid && id_ready; if_valid never depends on id_ready, and a redirect
  // in the same cycle discards the head instead of transferring it.

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) * 33'd4;

  state_t      state;
  state_t      state_next;
  logic        fetch_en;

  logic [31:0] pc;
  logic [31:0] pc_off;
  logic        out_of_range;
  logic        misaligned;

  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        pop;
  logic        push;

  // Offset from the window base; anything below the base wraps to a huge
  // unsigned value and therefore also counts as out of range.
  assign pc_off       = pc - RESET_PC;
  assign out_of_range = {1'b0, pc_off} >= IM_BYTES;
  assign misaligned   = redirect_pc[1:0] != 2'b00;
  assign im_addr      = pc_off[12:2];

  assign if_valid = count != 2'd0;
  assign if_instr = if_valid ? q_instr[rd_ptr]         : 32'd0;
  assign if_pc    = if_valid ? q_pc[rd_ptr]            : 32'd0;
  assign if_pc4   = if_valid ? q_pc[rd_ptr] + 32'd4    : 32'd0;

  assign pop  = if_valid && id_ready;
  assign push = fetch_en && !redirect_valid && !out_of_range &&
                ((count != 2'd2) || pop);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = misaligned ? FAULT : RUN;
    end else if (state == RUN && out_of_range) begin
      state_next = FAULT;
    end
  end

  // FSM outputs
  always_comb begin
    fetch_en    = 1'b0;
    fetch_fault = 1'b0;
    case (state)
      RUN:     fetch_en    = 1'b1;
      FAULT:   fetch_fault = 1'b1;
      default: fetch_fault = 1'b0;
    endcase
  end

  // PC, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      q_instr[wr_ptr] <= im_instr;
      q_pc[wr_ptr]    <= pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random redirect/stall traffic
// checked against a queue-based behavioural model.
module tb_instr_fetch;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam logic [31:0] BYTES = 32'd8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;
  logic [10:0] im_addr;
  logic [31:0] im_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  // reference model: queue of {instr, pc}, fetch pc and fault flag
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_fault;

  logic [108:0] got;

  always #5 clk = ~clk;

  // memory word k holds 32'h1000_0000 + k
  assign im_instr = 32'h1000_0000 + {21'd0, im_addr};
  assign got = {if_valid, if_instr, if_pc, if_pc4, fetch_fault, im_addr};

  instr_fetch #(.RESET_PC(BASE), .IM_WORDS(2048)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [108:0] exp_vec();
    logic [31:0] off;
    off = m_pc - BASE;
    if (exp_q.size() == 0) return {1'b0, 96'd0, m_fault, off[12:2]};
    return {1'b1, exp_q[0][63:32], exp_q[0][31:0], exp_q[0][31:0] + 32'd4,
            m_fault, off[12:2]};
  endfunction

  task automatic model_step(input logic rst, input logic rv,
                            input logic [31:0] rpc, input logic rdy);
    logic [31:0] off;
    logic        in_range;
    logic        do_pop;
    logic        do_fetch;
    if (!rst) begin
      exp_q.delete();
      m_pc    = BASE;
      m_fault = 1'b0;
    end else if (rv) begin
      exp_q.delete();
      m_pc    = rpc;
      m_fault = rpc[1:0] != 2'b00;
    end else begin
      off      = m_pc - BASE;
      in_range = off < BYTES;
      do_pop   = exp_q.size() > 0 && rdy;
      do_fetch = !m_fault && in_range && (exp_q.size() < 2 || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (do_fetch) begin
        exp_q.push_back({32'h1000_0000 + (off >> 2), m_pc});
        m_pc = m_pc + 32'd4;
      end else if (!m_fault && !in_range) begin
        m_fault = 1'b1;
      end
    end
  endtask

  // drive one cycle of inputs, advance the model, then settle past the edge
  task automatic tick(input logic rst, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    rst_n          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    model_step(rst, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 32'h0040_0104, 1'b1);
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (got !== 109'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected all zero", got);
    end
    checks++;
    if (got !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %h, expected %h", got, exp_vec());
    end
  endtask

  task automatic test_stream();
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 32'd0, 1'b1);
      e_instr = 32'h1000_0000 + 32'(i);
      e_pc    = BASE + 32'(4 * i);
      checks++;
      if (if_valid !== 1'b1 || if_instr !== e_instr || if_pc !== e_pc ||
          if_pc4 !== e_pc + 32'd4) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b instr=%h pc=%h pc4=%h, expected v=1 instr=%h pc=%h",
                 i, if_valid, if_instr, if_pc, if_pc4, e_instr, e_pc);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e_pc;
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'd0, 1'b0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== BASE || im_addr !== 11'd2) begin
      errors++;
      $display("FAIL stall_hold: got v=%b pc=%h im_addr=%0d, expected v=1 pc=%h im_addr=2",
               if_valid, if_pc, im_addr, BASE);
    end
    for (int j = 1; j <= 3; j++) begin
      tick(1'b1, 1'b0, 32'd0, 1'b1);
      e_pc = BASE + 32'(4 * j);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== e_pc || got !== exp_vec()) begin
        errors++;
        $display("FAIL stall_release[%0d]: got pc=%h vec=%h, expected pc=%h vec=%h",
                 j, if_pc, got, e_pc, exp_vec());
      end
    end
  endtask

  task automatic test_redirect();
    tick(1'b1, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b1, 32'h0040_0100, 1'b1);
    checks++;
    if (if_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL redirect_flush: got v=%b fault=%b, expected v=0 fault=0",
               if_valid, fetch_fault);
    end
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0040_0100 || if_instr !== 32'h1000_0040) begin
      errors++;
      $display("FAIL redirect_target: got v=%b pc=%h instr=%h, expected v=1 pc=00400100 instr=10000040",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_misaligned();
    tick(1'b1, 1'b1, 32'h0040_0102, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_fault !== 1'b1 || if_valid !== 1'b0) begin
        errors++;
        $display("FAIL misaligned_fault[%0d]: got fault=%b v=%b, expected fault=1 v=0",
                 i, fetch_fault, if_valid);
      end
      tick(1'b1, 1'b0, 32'd0, 1'b1);
    end
    tick(1'b1, 1'b1, 32'h0040_0010, 1'b1);
    checks++;
    if (fetch_fault !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_exit: got fault=%b v=%b, expected fault=0 v=0",
               fetch_fault, if_valid);
    end
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_instr !== 32'h1000_0004 || if_pc !== 32'h0040_0010) begin
      errors++;
      $display("FAIL misaligned_resume: got v=%b instr=%h pc=%h, expected v=1 instr=10000004 pc=00400010",
               if_valid, if_instr, if_pc);
    end
  endtask

  task automatic test_end_of_memory();
    logic saw_last = 1'b0;
    logic saw_fault = 1'b0;
    tick(1'b1, 1'b1, 32'h0040_1ff0, 1'b1);
    for (int i = 0; i < 20 && !saw_fault; i++) begin
      tick(1'b1, 1'b0, 32'd0, 1'b1);
      if (if_valid === 1'b1 && if_instr === 32'h1000_07ff) saw_last = 1'b1;
      if (fetch_fault === 1'b1) saw_fault = 1'b1;
    end
    checks++;
    if (!saw_last || !saw_fault || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL end_of_memory: got last_seen=%b fault_seen=%b v=%b, expected 1 1 0",
               saw_last, saw_fault, if_valid);
    end
    // fill to the end with decode stalled, then drain while faulted
    tick(1'b1, 1'b1, 32'h0040_1ff8, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'd0, 1'b0);
    checks++;
    if (fetch_fault !== 1'b1 || if_valid !== 1'b1 || if_instr !== 32'h1000_07fe) begin
      errors++;
      $display("FAIL end_full_fault: got fault=%b v=%b instr=%h, expected fault=1 v=1 instr=100007fe",
               fetch_fault, if_valid, if_instr);
    end
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_instr !== 32'h1000_07ff || if_pc !== 32'h0040_1ffc) begin
      errors++;
      $display("FAIL fault_drain: got v=%b instr=%h pc=%h, expected v=1 instr=100007ff pc=00401ffc",
               if_valid, if_instr, if_pc);
    end
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (if_valid !== 1'b0 || fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_empty: got v=%b fault=%b, expected v=0 fault=1", if_valid, fetch_fault);
    end
  endtask

  task automatic test_reset_midstream();
    tick(1'b1, 1'b1, 32'h0040_0020, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b1, 32'h0040_0100, 1'b1);
    checks++;
    if (got !== 109'd0) begin
      errors++;
      $display("FAIL reset_midstream: got %h, expected all zero", got);
    end
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== BASE || if_instr !== 32'h1000_0000) begin
      errors++;
      $display("FAIL reset_restart: got v=%b pc=%h instr=%h, expected v=1 pc=%h instr=10000000",
               if_valid, if_pc, if_instr, BASE);
    end
  endtask

  task automatic test_random();
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 99) != 0;
      rv  = $urandom_range(0, 15) == 0;
      rdy = $urandom_range(0, 9) < 7;
      case ($urandom_range(0, 3))
        0:       rpc = BASE + 32'($urandom_range(0, 2047)) * 32'd4;
        1:       rpc = BASE + 32'($urandom_range(0, 8191));
        2:       rpc = BASE + BYTES - 32'($urandom_range(1, 6)) * 32'd4;
        default: rpc = $urandom;
      endcase
      tick(rst, rv, rpc, rdy);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h, expected %h", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_end_of_memory();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
